// File: rtl/bus_read_return.sv
// bus_read_return: response side of the CPU peripheral bus.
// Registers the decoder's one-hot chip-select set for each CPU request, waits for
// the selected slave's ready, returns that slave's read data and pulses cpu_ready.
// Unmapped addresses, non-one-hot selects and slave timeouts get an error response
// carrying ERR_DATA.
//
// Optional feature macro: BUS_ERR_CAPTURE_EN
//   When defined, adds req_addr / err_addr / err_valid. The first error sets
//   err_valid, which then stays set until reset. Each error stores its request
//   address in err_addr.
//
// Handshake: req is a request strobe that is sampled only in IDLE. The CPU holds
// req, req_we and cs_* stable until it sees cpu_ready, which is a one-cycle
// completion pulse. cpu_err qualifies that pulse. A slave acknowledges with its
// rdy_* input, and its rdata_* is valid in the same cycle. A new request may be
// presented in the same cycle that cpu_ready is high.
//
// FSM state is visible on state_q, and busy is its registered decode.
module bus_read_return #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic        cs_mem,
    input  logic        cs_keypad,
    input  logic        cs_gpio,
    input  logic        cs_uart,
    input  logic        cs_spi,
    input  logic        rdy_mem,
    input  logic        rdy_keypad,
    input  logic        rdy_gpio,
    input  logic        rdy_uart,
    input  logic        rdy_spi,
    input  logic [31:0] rdata_mem,
    input  logic [31:0] rdata_keypad,
    input  logic [31:0] rdata_gpio,
    input  logic [31:0] rdata_uart,
    input  logic [31:0] rdata_spi,
`ifdef BUS_ERR_CAPTURE_EN
    input  logic [31:0] req_addr,
    output logic [31:0] err_addr,
    output logic        err_valid,
`endif
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Last WAIT count before giving up. The counter holds 0..TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [4:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    // Bit order everywhere: 0 mem, 1 keypad, 2 gpio, 3 uart, 4 spi.
    logic [4:0]       cs_vec;
    logic [4:0]       rdy_vec;
    logic             sel_rdy;
    logic [31:0]      sel_rdata;

    assign cs_vec  = {cs_spi, cs_uart, cs_gpio, cs_keypad, cs_mem};
    assign rdy_vec = {rdy_spi, rdy_uart, rdy_gpio, rdy_keypad, rdy_mem};

    // Ready and read data of the latched slave. sel_q is one-hot, so an AND-OR mux is enough.
    always_comb begin
        sel_rdy   = |(sel_q & rdy_vec);
        sel_rdata = ({32{sel_q[0]}} & rdata_mem)
                  | ({32{sel_q[1]}} & rdata_keypad)
                  | ({32{sel_q[2]}} & rdata_gpio)
                  | ({32{sel_q[3]}} & rdata_uart)
                  | ({32{sel_q[4]}} & rdata_spi);
    end

    // Next-state and response logic. Response outputs default to idle and rdata holds.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if ($onehot(cs_vec)) begin
                        sel_d   = cs_vec;
                        we_d    = req_we;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end else begin
                        // Either no select or several selects: answer at once, stay in IDLE.
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end
                end
            end
            WAIT: begin
                if (sel_rdy) begin
                    // Ready takes priority over a timeout in the same cycle.
                    ready_d = 1'b1;
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    // The saturation guard keeps the counter from wrapping for any parameter choice.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WAIT);
    end

    // State and response registers, with synchronous reset to all zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign cpu_err   = err_q;
    assign busy      = busy_q;

`ifdef BUS_ERR_CAPTURE_EN
    logic [31:0] addr_q, addr_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_valid_q, err_valid_d;

    // Latch the request address. Record it whenever an error response is issued.
    always_comb begin
        addr_d      = addr_q;
        err_addr_d  = err_addr_q;
        err_valid_d = err_valid_q;
        if (state_q == IDLE && req) begin
            addr_d = req_addr;
        end
        if (err_d) begin
            // An unmapped request never reaches WAIT, so its address comes straight from req_addr.
            err_addr_d  = (state_q == IDLE) ? req_addr : addr_q;
            err_valid_d = 1'b1;
        end
    end

    // Error-capture registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            err_addr_q  <= '0;
            err_valid_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            err_addr_q  <= err_addr_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign err_addr  = err_addr_q;
    assign err_valid = err_valid_q;
`endif

endmodule
